// File: rtl/uart_rx_controller.sv
// UART receive sequencer: start detection, 3-sample majority voting per bit,
// parity/framing checks and a valid/ready output register with overrun flag.
module uart_rx_controller #(
    parameter int DATA_BITS       = 8,
    parameter int SAMPLES_PER_BIT = 16,
    parameter int PARITY_ODD      = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RxD,
    input  logic                 Rx_EN,
    input  logic                 Rx_sample_ENABLE,
    input  logic                 Rx_READY,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR,
    output logic                 Rx_OVERRUN,
    output logic                 Rx_BUSY
);

    localparam int TW  = $clog2(SAMPLES_PER_BIT);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam int MID = SAMPLES_PER_BIT / 2;

    localparam logic [TW-1:0] TICK_S0   = TW'(MID - 1);
    localparam logic [TW-1:0] TICK_S1   = TW'(MID);
    localparam logic [TW-1:0] TICK_S2   = TW'(MID + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLES_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DELIVER, S_BREAK
    } state_t;

    state_t                 state, state_next;
    logic                   rxd_meta, rxd_s;
    logic [TW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic [2:0]             samp;
    logic                   perr, ferr;
    logic                   tick, end_tick, in_frame, s2_eff, bit_val;
    logic                   consume, deliver;

    assign tick     = Rx_sample_ENABLE;
    assign end_tick = tick && (tick_cnt == TICK_LAST);
    assign in_frame = (state == S_START) || (state == S_DATA) ||
                      (state == S_PARITY) || (state == S_STOP);
    // With SAMPLES_PER_BIT=4 the third sample lands on the end tick itself.
    assign s2_eff   = (tick_cnt == TICK_S2) ? rxd_s : samp[2];
    assign bit_val  = (samp[0] & samp[1]) | (samp[0] & s2_eff) | (samp[1] & s2_eff);
    assign consume  = Rx_VALID && Rx_READY;
    assign deliver  = (state == S_DELIVER) && Rx_EN;
    assign Rx_BUSY  = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
            rxd_meta <= RxD;
            rxd_s    <= rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            S_IDLE:    if (tick && !rxd_s) state_next = S_START;
            S_START:   if (end_tick) state_next = bit_val ? S_IDLE : S_DATA;
            S_DATA:    if (end_tick && bit_cnt == BIT_LAST) state_next = S_PARITY;
            S_PARITY:  if (end_tick) state_next = S_STOP;
            S_STOP:    if (end_tick) state_next = S_DELIVER;
            S_DELIVER: state_next = ferr ? S_BREAK : S_IDLE;
            S_BREAK:   if (tick && rxd_s) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        if (!Rx_EN) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            samp     <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
        end else if (!Rx_EN) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state == S_IDLE) begin
            // The start-detecting tick is tick 0 of the start bit.
            if (tick && !rxd_s) tick_cnt <= TW'(1);
        end else if (in_frame && tick) begin
            tick_cnt <= end_tick ? '0 : tick_cnt + 1'b1;
            if (tick_cnt == TICK_S0) samp[0] <= rxd_s;
            if (tick_cnt == TICK_S1) samp[1] <= rxd_s;
            if (tick_cnt == TICK_S2) samp[2] <= rxd_s;
            if (end_tick) begin
                case (state)
                    S_START:  bit_cnt <= '0;
                    S_DATA: begin
                        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    S_PARITY: perr <= bit_val ^ (^shreg) ^ PAR_ODD;
                    S_STOP:   ferr <= ~bit_val;
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Rx_DATA    <= '0;
            Rx_VALID   <= 1'b0;
            Rx_PERROR  <= 1'b0;
            Rx_FERROR  <= 1'b0;
            Rx_OVERRUN <= 1'b0;
        end else if (deliver) begin
            Rx_DATA   <= shreg;
            Rx_PERROR <= perr;
            Rx_FERROR <= ferr;
            Rx_VALID  <= 1'b1;
            if (Rx_VALID && !Rx_READY) Rx_OVERRUN <= 1'b1;
            else if (consume)          Rx_OVERRUN <= 1'b0;
        end else if (consume) begin
            Rx_VALID   <= 1'b0;
            Rx_OVERRUN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: plays tick-by-tick line levels and compares
// against a frame-level model (majority decode, parity, framing, handshake).
module tb_uart_rx_controller;

    localparam int SPB = 16;
    localparam int NB  = 11;
    localparam int NT  = NB * SPB;
    localparam int MID = SPB / 2;

    logic       clk = 1'b0;
    logic       reset, RxD, Rx_EN, Rx_sample_ENABLE, Rx_READY;
    logic [7:0] e_data, o_data;
    logic       e_valid, e_perr, e_ferr, e_ovr, e_busy;
    logic       o_valid, o_perr, o_ferr, o_ovr, o_busy;

    int errors = 0;
    int checks = 0;

    logic       lv [NT];
    logic [7:0] m_data;
    logic       m_perr_even, m_perr_odd, m_ferr;
    logic [7:0] exp_data;
    logic       exp_valid, exp_perr, exp_ferr, exp_ovr;

    uart_rx_controller #(.DATA_BITS(8), .SAMPLES_PER_BIT(SPB), .PARITY_ODD(0)) dut (
        .clk(clk), .reset(reset), .RxD(RxD), .Rx_EN(Rx_EN),
        .Rx_sample_ENABLE(Rx_sample_ENABLE), .Rx_READY(Rx_READY),
        .Rx_DATA(e_data), .Rx_VALID(e_valid), .Rx_PERROR(e_perr),
        .Rx_FERROR(e_ferr), .Rx_OVERRUN(e_ovr), .Rx_BUSY(e_busy)
    );

    uart_rx_controller #(.DATA_BITS(8), .SAMPLES_PER_BIT(SPB), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .reset(reset), .RxD(RxD), .Rx_EN(Rx_EN),
        .Rx_sample_ENABLE(Rx_sample_ENABLE), .Rx_READY(Rx_READY),
        .Rx_DATA(o_data), .Rx_VALID(o_valid), .Rx_PERROR(o_perr),
        .Rx_FERROR(o_ferr), .Rx_OVERRUN(o_ovr), .Rx_BUSY(o_busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One oversampling period: line level settles through the synchronizer, then one tick pulse.
    task automatic slot(input logic level);
        RxD = level;
        repeat (2 + $urandom_range(0, 1)) cyc();
        Rx_sample_ENABLE = 1'b1;
        cyc();
        Rx_sample_ENABLE = 1'b0;
    endtask

    task automatic build_frame(input logic [7:0] d, input logic par_flip,
                               input logic stop_bit, input int glitch_idx);
        logic [10:0] fb, dec;
        int v;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = d[i];
        fb[9]  = (^d) ^ par_flip;
        fb[10] = stop_bit;
        for (int i = 0; i < NT; i++) lv[i] = fb[i/SPB];
        if (glitch_idx >= 0) lv[glitch_idx] = ~lv[glitch_idx];
        for (int b = 0; b < NB; b++) begin
            v = int'(lv[b*SPB+MID-1]) + int'(lv[b*SPB+MID]) + int'(lv[b*SPB+MID+1]);
            dec[b] = (v >= 2);
        end
        m_data      = dec[8:1];
        m_perr_even = dec[9] ^ (^dec[8:1]);
        m_perr_odd  = ~m_perr_even;
        m_ferr      = ~dec[10];
    endtask

    task automatic play(input int from, input int to);
        for (int i = from; i < to; i++) slot(lv[i]);
    endtask

    // Plays a whole frame and verifies delivery timing and contents.
    task automatic send_frame(input string name, input logic [7:0] d, input logic par_flip,
                              input logic stop_bit, input int glitch_idx, input logic rdy);
        build_frame(d, par_flip, stop_bit, glitch_idx);
        play(0, NT);
        checks++;
        if (e_valid !== exp_valid || e_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: valid=%b busy=%b, required valid=%b busy=1", name, e_valid, e_busy, exp_valid);
        end
        Rx_READY = rdy;
        cyc();
        Rx_READY = 1'b0;
        if (exp_valid && !rdy)     exp_ovr = 1'b1;
        else if (exp_valid && rdy) exp_ovr = 1'b0;
        exp_valid = 1'b1;
        exp_data  = m_data;
        exp_perr  = m_perr_even;
        exp_ferr  = m_ferr;
        checks++;
        if (e_data !== exp_data) begin
            errors++;
            $display("FAIL %s data: got %h, required %h", name, e_data, exp_data);
        end
        checks++;
        if (e_valid !== 1'b1 || e_busy !== m_ferr) begin
            errors++;
            $display("FAIL %s valid/busy: got %b/%b, required 1/%b", name, e_valid, e_busy, m_ferr);
        end
        checks++;
        if (e_perr !== exp_perr || e_ferr !== exp_ferr) begin
            errors++;
            $display("FAIL %s perr/ferr: got %b/%b, required %b/%b", name, e_perr, e_ferr, exp_perr, exp_ferr);
        end
        checks++;
        if (e_ovr !== exp_ovr) begin
            errors++;
            $display("FAIL %s overrun: got %b, required %b", name, e_ovr, exp_ovr);
        end
        checks++;
        if (o_perr !== m_perr_odd || o_data !== m_data) begin
            errors++;
            $display("FAIL %s odd-parity: got perr=%b data=%h, required perr=%b data=%h", name, o_perr, o_data, m_perr_odd, m_data);
        end
    endtask

    task automatic consume(input string name);
        Rx_READY = 1'b1;
        cyc();
        Rx_READY = 1'b0;
        if (exp_valid) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end
        checks++;
        if (e_valid !== exp_valid || e_ovr !== exp_ovr) begin
            errors++;
            $display("FAIL %s consume: valid=%b ovr=%b, required %b/%b", name, e_valid, e_ovr, exp_valid, exp_ovr);
        end
    endtask

    task automatic idle_slots(input int n);
        for (int i = 0; i < n; i++) slot(1'b1);
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (e_data !== 8'h00 || e_valid !== 1'b0 || e_perr !== 1'b0 || e_ferr !== 1'b0 ||
            e_ovr !== 1'b0 || e_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: data=%h valid=%b perr=%b ferr=%b ovr=%b busy=%b, required all 0",
                     name, e_data, e_valid, e_perr, e_ferr, e_ovr, e_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; RxD = 1'b1; Rx_EN = 1'b0; Rx_sample_ENABLE = 1'b0; Rx_READY = 1'b0;
        exp_valid = 1'b0; exp_data = 8'h00; exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
        repeat (3) cyc();
        check_all_zero("reset");
        reset = 1'b1;
        Rx_EN = 1'b1;
        idle_slots(2);
        check_all_zero("post-reset idle");
    endtask

    task automatic test_basic();
        send_frame("basic 5A", 8'h5A, 1'b0, 1'b1, -1, 1'b0);
        consume("basic 5A");
        // Ready with nothing valid must be ignored.
        Rx_READY = 1'b1;
        repeat (3) cyc();
        Rx_READY = 1'b0;
        checks++;
        if (e_valid !== 1'b0 || e_data !== exp_data) begin
            errors++;
            $display("FAIL idle ready: valid=%b data=%h, required 0/%h", e_valid, e_data, exp_data);
        end
    endtask

    task automatic test_parity();
        send_frame("parity 5A bad", 8'h5A, 1'b1, 1'b1, -1, 1'b0);
        consume("parity");
    endtask

    task automatic test_framing();
        send_frame("framing 00", 8'h00, 1'b0, 1'b0, -1, 1'b0);
        for (int i = 0; i < 6; i++) slot(1'b0);
        checks++;
        if (e_busy !== 1'b1 || e_valid !== 1'b1 || e_data !== 8'h00) begin
            errors++;
            $display("FAIL break hold: busy=%b valid=%b data=%h, required 1/1/00", e_busy, e_valid, e_data);
        end
        slot(1'b1);
        checks++;
        if (e_busy !== 1'b0) begin
            errors++;
            $display("FAIL break release: busy=%b, required 0", e_busy);
        end
        consume("framing");
    endtask

    task automatic test_false_start();
        for (int i = 0; i < 5; i++) slot(1'b0);
        checks++;
        if (e_busy !== 1'b1) begin
            errors++;
            $display("FAIL false start detect: busy=%b, required 1", e_busy);
        end
        idle_slots(12);
        checks++;
        if (e_busy !== 1'b0 || e_valid !== exp_valid) begin
            errors++;
            $display("FAIL false start drop: busy=%b valid=%b, required 0/%b", e_busy, e_valid, exp_valid);
        end
    endtask

    task automatic test_glitch();
        send_frame("glitch FF", 8'hFF, 1'b0, 1'b1, (1 + 3) * SPB + MID, 1'b0);
        consume("glitch");
    endtask

    task automatic test_back_to_back();
        send_frame("b2b 11", 8'h11, 1'b0, 1'b1, -1, 1'b0);
        send_frame("b2b 22 overrun", 8'h22, 1'b0, 1'b1, -1, 1'b0);
        consume("b2b overrun");
        send_frame("b2b 11 again", 8'h11, 1'b0, 1'b1, -1, 1'b0);
        send_frame("b2b 22 ready", 8'h22, 1'b0, 1'b1, -1, 1'b1);
        consume("b2b ready");
    endtask

    task automatic test_enable();
        build_frame(8'hA5, 1'b0, 1'b1, -1);
        play(0, 5 * SPB + 6);
        Rx_EN = 1'b0;
        cyc();
        checks++;
        if (e_busy !== 1'b0) begin
            errors++;
            $display("FAIL enable drop: busy=%b, required 0", e_busy);
        end
        idle_slots(3);
        checks++;
        if (e_valid !== exp_valid) begin
            errors++;
            $display("FAIL enable discard: valid=%b, required %b", e_valid, exp_valid);
        end
        Rx_EN = 1'b1;
        idle_slots(2);
        send_frame("enable C3", 8'hC3, 1'b0, 1'b1, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        send_frame("pre-reset 3C", 8'h3C, 1'b0, 1'b1, -1, 1'b0);
        build_frame(8'h96, 1'b0, 1'b1, -1);
        play(0, 9 * SPB + 5);
        reset = 1'b0;
        #1;
        exp_valid = 1'b0; exp_data = 8'h00; exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
        check_all_zero("reset mid-parity");
        RxD = 1'b1;
        cyc();
        reset = 1'b1;
        idle_slots(2);
        send_frame("after reset 81", 8'h81, 1'b0, 1'b1, -1, 1'b0);
        consume("after reset");
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       pf, rdy;
        for (int n = 0; n < 10; n++) begin
            d   = 8'($urandom);
            pf  = ($urandom_range(0, 3) == 0);
            rdy = 1'($urandom);
            send_frame($sformatf("random %0d", n), d, pf, 1'b1, -1, rdy);
            if ($urandom_range(0, 1) == 1) consume($sformatf("random %0d", n));
            idle_slots($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_false_start();
        test_glitch();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
